controller_unit: RTL and testbench
==================================

CONTROLLER_UNIT -- requirements
Module: controller_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge system clock; reset input 1 synchronous active-high reset.
REQ-002 The block SHALL provide `PC_addr`: output, 7 bits, instruction-memory word address (equal to the current PC).
REQ-003 The block SHALL provide `instr_data`: input, 16 bits, instruction word, combinationally valid for `PC_addr` in the same cycle.
REQ-004 The block SHALL provide `D_addr`: output, 8 bits, data-memory address.
REQ-005 The block SHALL provide `D_wr`: output, 1 bit, data-memory write enable.
REQ-006 The block SHALL provide `RF_sel`: output, 1 bit, write-back select (1 = data memory, 0 = ALU).
REQ-007 The block SHALL provide `RF_W_en`: output, 1 bit, register-file write enable.
REQ-008 The block SHALL provide `ALU_s0`: output, 3 bits, ALU function select.
REQ-009 The block SHALL provide `WriteAddr`, `rdAddrA` and `rdAddrB`: outputs, 4 bits each, register-file addresses.
REQ-010 The block SHALL provide monitor outputs: `state_out` (4 bits, current state), `ir_out` (16 bits, IR) and `halted` (1 bit, high in HALT).

Function
REQ-011 The FSM SHALL have the states INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, NOOP and HALT.
REQ-012 Transitions SHALL be: INIT->FETCH; FETCH->DECODE; DECODE->execute state chosen by IR[15:12]; LOAD_A->LOAD_B; LOAD_B, STORE, ADD, SUB and NOOP->FETCH; HALT->HALT until reset.
REQ-013 The opcode encodings SHALL be NOOP=0000, STORE=0001, LOAD=0010, ADD=0011, SUB=0100, HALT=0101; any other opcode SHALL decode as NOOP.
REQ-014 In FETCH: IR SHALL be loaded from `instr_data` and PC SHALL be incremented modulo 128 (127 wraps to 0), both at the FETCH clock edge.
REQ-015 Register fields SHALL be decoded from IR as rdAddrA=IR[11:8], rdAddrB=IR[7:4], WriteAddr=IR[3:0], and driven in every state.
REQ-016 D_addr SHALL be IR[11:4] in LOAD_A/LOAD_B, IR[7:0] in STORE, and 0 otherwise.
REQ-017 Control outputs SHALL be Moore-decoded from state only; anything not listed below SHALL be 0.
  - LOAD_A: RF_sel=1.
  - LOAD_B: RF_sel=1, RF_W_en=1.
  - STORE: D_wr=1.
  - ADD: ALU_s0=001, RF_W_en=1.
  - SUB: ALU_s0=010, RF_W_en=1.
REQ-018 Instruction latency SHALL be 4 cycles for LOAD and 3 cycles for all other instructions (FETCH to return to FETCH); HALT takes 2 cycles to reach HALT.
REQ-019 D_wr and RF_W_en SHALL never be high in the same cycle.
REQ-020 In HALT, all write enables SHALL stay 0, PC and IR SHALL hold, and `halted` SHALL be 1.

Reset
REQ-021 When reset is sampled high at a clock edge, state SHALL become INIT, PC SHALL become 0 and IR SHALL become 0000, from any state (including mid-LOAD or HALT).
REQ-022 In INIT all control outputs SHALL be 0 and `halted` SHALL be 0; reset has priority over every transition.

Configuration
REQ-023 When macro `CTRL_ILLEGAL_HALT_EN` is defined, undefined opcodes (0110-1111) SHALL transition DECODE->HALT.
REQ-024 When `CTRL_ILLEGAL_HALT_EN` is undefined, undefined opcodes SHALL execute as NOOP; ports and all other behaviour SHALL be identical in both builds.

Structure
REQ-025 Package `ctrl_pkg` SHALL hold the state enum (4-bit encoding), the opcode constants and the ALU select constants (PASS=000, ADD=001, SUB=010).
REQ-026 The PC (7-bit register with clear and increment enable) SHALL be a separate sub-module `program_counter`; the FSM, IR and output decode SHALL reside in `controller_unit`.

Verification
REQ-027 Reset release: reset high 2 cycles then low -> INIT, then FETCH on the next cycle, with PC_addr=0 and all enables 0.
REQ-028 LOAD test: instr_data=16'h2011 -> LOAD_A with D_addr=8'h01, RF_sel=1, RF_W_en=0; then LOAD_B with RF_W_en=1, WriteAddr=1; then FETCH with PC=1.
REQ-029 STORE and ADD test: 16'h116A then 16'h3123 -> STORE asserts D_wr=1, D_addr=8'h6A, rdAddrA=1; ADD asserts ALU_s0=001, RF_W_en=1, rdAddrA=1, rdAddrB=2, WriteAddr=3.
REQ-030 PC wrap: PC preset via 127 NOOPs, then fetch at address 127 -> PC_addr becomes 0.
REQ-031 Illegal opcode: 16'hF000 -> NOOP path in the default build; HALT with `halted`=1 when `CTRL_ILLEGAL_HALT_EN` is defined.
REQ-032 Reset mid-operation: HALT 16'h5000 -> `halted`=1 held for 10 cycles with PC frozen; reset asserted in LOAD_B -> next state INIT with RF_W_en=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the controller: state encoding, opcodes, ALU selects.
// CTRL_ILLEGAL_HALT_EN: when defined, undefined opcodes decode to HALT instead of NOOP.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Execute state entered from DECODE for a given opcode.
  function automatic state_e decode_exec(input logic [3:0] opcode);
    state_e nxt;
    case (opcode)
      OP_NOOP:  nxt = S_NOOP;
      OP_STORE: nxt = S_STORE;
      OP_LOAD:  nxt = S_LOAD_A;
      OP_ADD:   nxt = S_ADD;
      OP_SUB:   nxt = S_SUB;
      OP_HALT:  nxt = S_HALT;
`ifdef CTRL_ILLEGAL_HALT_EN
      default:  nxt = S_HALT;
`else
      default:  nxt = S_NOOP;
`endif
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/program_counter.sv
// 7-bit program counter: synchronous clear has priority over increment; wraps 127 -> 0.
module program_counter (
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       inc_en_i,
  output logic [6:0] pc_o
);

  logic [6:0] pc_q;
  logic [6:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_en_i) pc_d = pc_q + 7'd1;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) pc_q <= 7'd0;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/controller_unit.sv
// Multi-cycle instruction controller: FETCH/DECODE/execute FSM, IR, Moore output decode.
// instr_data is expected combinationally valid for PC_addr in the same cycle.
module controller_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [6:0]  PC_addr,
  input  logic [15:0] instr_data,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_sel,
  output logic        RF_W_en,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  WriteAddr,
  output logic [3:0]  rdAddrA,
  output logic [3:0]  rdAddrB,
  output logic [3:0]  state_out,
  output logic [15:0] ir_out,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [6:0]  pc;

  program_counter u_pc (
    .clk_i    (clk),
    .clear_i  (reset),
    .inc_en_i (state_q == S_FETCH),
    .pc_o     (pc)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = instr_data;
      end
      S_DECODE: state_d = decode_exec(ir_q[15:12]);
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Control strobes depend on state only, so they are glitch-free relative to instr_data.
  always_comb begin
    D_addr  = 8'h00;
    D_wr    = 1'b0;
    RF_sel  = 1'b0;
    RF_W_en = 1'b0;
    ALU_s0  = ALU_PASS;
    halted  = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        D_addr = ir_q[11:4];
        RF_sel = 1'b1;
      end
      S_LOAD_B: begin
        D_addr  = ir_q[11:4];
        RF_sel  = 1'b1;
        RF_W_en = 1'b1;
      end
      S_STORE: begin
        D_addr = ir_q[7:0];
        D_wr   = 1'b1;
      end
      S_ADD: begin
        ALU_s0  = ALU_ADD;
        RF_W_en = 1'b1;
      end
      S_SUB: begin
        ALU_s0  = ALU_SUB;
        RF_W_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_addr   = pc;
  assign rdAddrA   = ir_q[11:8];
  assign rdAddrB   = ir_q[7:4];
  assign WriteAddr = ir_q[3:0];
  assign state_out = state_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_controller_unit.sv
// Scoreboard bench for controller_unit: cycle-stamped expected output vectors, checked by a monitor.
module tb_controller_unit;
  import ctrl_pkg::*;

  localparam int W = 54;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  PC_addr;
  logic [15:0] instr_data;
  logic [7:0]  D_addr;
  logic        D_wr, RF_sel, RF_W_en, halted;
  logic [2:0]  ALU_s0;
  logic [3:0]  WriteAddr, rdAddrA, rdAddrB, state_out;
  logic [15:0] ir_out;

  logic [15:0] imem [128];

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_name_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instr_data = imem[PC_addr];

  controller_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PC_addr    (PC_addr),
    .instr_data (instr_data),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_sel     (RF_sel),
    .RF_W_en    (RF_W_en),
    .ALU_s0     (ALU_s0),
    .WriteAddr  (WriteAddr),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .state_out  (state_out),
    .ir_out     (ir_out),
    .halted     (halted)
  );

  function automatic logic [W-1:0] pack(input logic [3:0] st, input logic [6:0] pc,
                                        input logic [15:0] ir, input logic [7:0] da,
                                        input logic dw, input logic rs, input logic we,
                                        input logic [2:0] alu, input logic h);
    return {st, pc, ir, da, dw, rs, we, alu, ir[3:0], ir[11:8], ir[7:4], h};
  endfunction

  // driver tasks
  task automatic expect_at(input int c, input logic [3:0] st, input logic [6:0] pc,
                           input logic [15:0] ir, input logic [7:0] da, input logic dw,
                           input logic rs, input logic we, input logic [2:0] alu,
                           input logic h, input string name);
    exp_q.push_back(pack(st, pc, ir, da, dw, rs, we, alu, h));
    exp_cyc_q.push_back(c);
    exp_name_q.push_back(name);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    string        nm;
    act = {state_out, PC_addr, ir_out, D_addr, D_wr, RF_sel, RF_W_en, ALU_s0,
           WriteAddr, rdAddrA, rdAddrB, halted};
    if (cyc >= 1) begin
      n_checks++;
      if (D_wr && RF_W_en) begin
        n_errors++;
        $display("FAIL excl_we cyc=%0d got D_wr=%b RF_W_en=%b required not both 1", cyc, D_wr, RF_W_en);
      end
    end
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      exp_v = exp_q.pop_front();
      nm    = exp_name_q.pop_front();
      n_checks++;
      if (exp_cyc_q[0] != cyc) begin
        n_errors++;
        $display("FAIL %s missed cycle %0d (now %0d)", nm, exp_cyc_q[0], cyc);
      end else if (act !== exp_v) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, exp_v);
      end
      void'(exp_cyc_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    imem[0] = 16'h2011;
    imem[1] = 16'h116A;
    imem[2] = 16'h3123;
    imem[3] = 16'h4321;
    imem[4] = 16'hF000;
    imem[5] = 16'h5000;

    // reset and release
    expect_at(1,  S_INIT,   7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "reset_init1");
    expect_at(2,  S_INIT,   7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "reset_init2");
    expect_at(3,  S_FETCH,  7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "release_fetch");
    // LOAD 2011
    expect_at(4,  S_DECODE, 7'd1, 16'h2011, 8'h00, 0, 0, 0, 3'b000, 0, "load_decode");
    expect_at(5,  S_LOAD_A, 7'd1, 16'h2011, 8'h01, 0, 1, 0, 3'b000, 0, "load_a");
    expect_at(6,  S_LOAD_B, 7'd1, 16'h2011, 8'h01, 0, 1, 1, 3'b000, 0, "load_b");
    expect_at(7,  S_FETCH,  7'd1, 16'h2011, 8'h00, 0, 0, 0, 3'b000, 0, "load_ret_fetch");
    // STORE 116A
    expect_at(8,  S_DECODE, 7'd2, 16'h116A, 8'h00, 0, 0, 0, 3'b000, 0, "store_decode");
    expect_at(9,  S_STORE,  7'd2, 16'h116A, 8'h6A, 1, 0, 0, 3'b000, 0, "store_exec");
    expect_at(10, S_FETCH,  7'd2, 16'h116A, 8'h00, 0, 0, 0, 3'b000, 0, "store_ret_fetch");
    // ADD 3123
    expect_at(11, S_DECODE, 7'd3, 16'h3123, 8'h00, 0, 0, 0, 3'b000, 0, "add_decode");
    expect_at(12, S_ADD,    7'd3, 16'h3123, 8'h00, 0, 0, 1, 3'b001, 0, "add_exec");
    expect_at(13, S_FETCH,  7'd3, 16'h3123, 8'h00, 0, 0, 0, 3'b000, 0, "add_ret_fetch");
    // SUB 4321
    expect_at(14, S_DECODE, 7'd4, 16'h4321, 8'h00, 0, 0, 0, 3'b000, 0, "sub_decode");
    expect_at(15, S_SUB,    7'd4, 16'h4321, 8'h00, 0, 0, 1, 3'b010, 0, "sub_exec");
    expect_at(16, S_FETCH,  7'd4, 16'h4321, 8'h00, 0, 0, 0, 3'b000, 0, "sub_ret_fetch");
    // illegal F000
    expect_at(17, S_DECODE, 7'd5, 16'hF000, 8'h00, 0, 0, 0, 3'b000, 0, "illegal_decode");
`ifdef CTRL_ILLEGAL_HALT_EN
    for (int c = 18; c <= 30; c++)
      expect_at(c, S_HALT, 7'd5, 16'hF000, 8'h00, 0, 0, 0, 3'b000, 1, "illegal_halt_hold");
`else
    expect_at(18, S_NOOP,   7'd5, 16'hF000, 8'h00, 0, 0, 0, 3'b000, 0, "illegal_noop");
    expect_at(19, S_FETCH,  7'd5, 16'hF000, 8'h00, 0, 0, 0, 3'b000, 0, "illegal_ret_fetch");
    expect_at(20, S_DECODE, 7'd6, 16'h5000, 8'h00, 0, 0, 0, 3'b000, 0, "halt_decode");
    for (int c = 21; c <= 30; c++)
      expect_at(c, S_HALT, 7'd6, 16'h5000, 8'h00, 0, 0, 0, 3'b000, 1, "halt_hold");
`endif
    // reset out of HALT, then reset in LOAD_B
    expect_at(31, S_INIT,   7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "reset_from_halt");
    expect_at(32, S_FETCH,  7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "refetch");
    expect_at(33, S_DECODE, 7'd1, 16'h2011, 8'h00, 0, 0, 0, 3'b000, 0, "load2_decode");
    expect_at(34, S_LOAD_A, 7'd1, 16'h2011, 8'h01, 0, 1, 0, 3'b000, 0, "load2_a");
    expect_at(35, S_LOAD_B, 7'd1, 16'h2011, 8'h01, 0, 1, 1, 3'b000, 0, "load2_b");
    expect_at(36, S_INIT,   7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "reset_from_load_b");
    // NOOP sweep to PC wrap
    expect_at(37, S_FETCH,  7'd0, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_fetch0");
    expect_at(38, S_DECODE, 7'd1, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_decode");
    expect_at(39, S_NOOP,   7'd1, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_noop");
    expect_at(40, S_FETCH,  7'd1, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_fetch1");
    expect_at(415, S_FETCH,  7'd126, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_fetch126");
    expect_at(416, S_DECODE, 7'd127, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "sweep_decode127");
    expect_at(418, S_FETCH,  7'd127, 16'h0000, 8'h00, 0, 0, 0, 3'b000, 0, "fetch_at_127");
    expect_at(419, S_DECODE, 7'd0, 16'h3123, 8'h00, 0, 0, 0, 3'b000, 0, "pc_wrap");
    expect_at(420, S_ADD,    7'd0, 16'h3123, 8'h00, 0, 0, 1, 3'b001, 0, "wrap_add");
    expect_at(421, S_FETCH,  7'd0, 16'h3123, 8'h00, 0, 0, 0, 3'b000, 0, "wrap_ret_fetch");

    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(30);
    reset = 1'b1;
    wait_cyc(31);
    reset = 1'b0;
    wait_cyc(35);
    reset = 1'b1;
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    imem[127] = 16'h3123;
    wait_cyc(36);
    reset = 1'b0;
    wait_cyc(423);

    // final report
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
